// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result/flag writeback with status register, flag stack and branch condition
// Optional feature macro: FLAG_STACK_EN (flag stack for interrupt entry/return)
module alu_writeback #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       capture,
  input  logic [7:0] alu_result,
  input  logic [2:0] alu_flags,
  input  logic [1:0] flag_op,
  input  logic [2:0] flag_mask,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] cond_sel,
  output logic [7:0] result_q,
  output logic [2:0] flags_q,
  output logic       cond_true,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err
);

  // Flag bit positions within {C,N,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  logic       pop_ok;
  logic [2:0] pop_flags;
  logic [2:0] flags_next;

`ifdef FLAG_STACK_EN
  localparam int PW = $clog2(STACK_DEPTH);

  logic [2:0]  stack_mem [STACK_DEPTH];
  logic [PW:0] occ_q;
  logic        err_q;
  logic        push_ok;
  logic        push_over;
  logic        pop_under;
  logic [PW-1:0] top_idx;

  assign stack_empty = (occ_q == '0);
  assign stack_full  = (occ_q == (PW+1)'(STACK_DEPTH));
  assign stack_err   = err_q;

  // Simultaneous push and pop cancel each other out entirely.
  assign push_ok   = push && !pop && !stack_full;
  assign pop_ok    = pop && !push && !stack_empty;
  assign push_over = push && !pop && stack_full;
  assign pop_under = pop && !push && stack_empty;

  assign top_idx   = PW'(occ_q - (PW+1)'(1));
  assign pop_flags = stack_mem[top_idx];

  // Stack storage: entries above the pointer are simply unreachable, so no reset.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      stack_mem[occ_q[PW-1:0]] <= flags_q;
    end
  end

  // Occupancy pointer and sticky overflow/underflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push_ok) begin
        occ_q <= occ_q + (PW+1)'(1);
      end else if (pop_ok) begin
        occ_q <= occ_q - (PW+1)'(1);
      end
      if (push_over || pop_under) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_stack_in;

  assign pop_ok          = 1'b0;
  assign pop_flags       = 3'b000;
  assign stack_empty     = 1'b1;
  assign stack_full      = 1'b0;
  assign stack_err       = 1'b0;
  assign unused_stack_in = push ^ pop ^ (STACK_DEPTH > 16);
`endif

  // Next status value: stack restore beats capture, capture beats flag_op.
  always_comb begin
    flags_next = flags_q;
    if (pop_ok) begin
      flags_next = pop_flags;
    end else if (capture) begin
      flags_next = alu_flags;
    end else begin
      case (flag_op)
        2'b01:   flags_next = flags_q | flag_mask;
        2'b10:   flags_next = flags_q & ~flag_mask;
        2'b11:   flags_next = flags_q ^ flag_mask;
        default: flags_next = flags_q;
      endcase
    end
  end

  // Result and status registers; reset leaves Z set.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= 8'h00;
      flags_q  <= 3'b001;
    end else begin
      if (capture) begin
        result_q <= alu_result;
      end
      flags_q <= flags_next;
    end
  end

  // Branch condition decode on the registered flags.
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flags_q[FLAG_Z];
      3'b010:  cond_true = !flags_q[FLAG_Z];
      3'b011:  cond_true = flags_q[FLAG_C];
      3'b100:  cond_true = !flags_q[FLAG_C];
      3'b101:  cond_true = flags_q[FLAG_N];
      3'b110:  cond_true = !flags_q[FLAG_N];
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - scoreboard bench for alu_writeback, expectations follow FLAG_STACK_EN
module tb_alu_writeback;

`ifdef FLAG_STACK_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       capture;
  logic [7:0] alu_result;
  logic [2:0] alu_flags;
  logic [1:0] flag_op;
  logic [2:0] flag_mask;
  logic       push;
  logic       pop;
  logic [2:0] cond_sel;
  logic [7:0] result_q;
  logic [2:0] flags_q;
  logic       cond_true;
  logic       stack_empty;
  logic       stack_full;
  logic       stack_err;

  typedef struct {
    string      nm;
    logic [7:0] res;
    logic [2:0] flags;
    logic       empty;
    logic       full;
    logic       err;
    logic       cond;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  alu_writeback #(.STACK_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .capture(capture), .alu_result(alu_result),
    .alu_flags(alu_flags), .flag_op(flag_op), .flag_mask(flag_mask),
    .push(push), .pop(pop), .cond_sel(cond_sel), .result_q(result_q),
    .flags_q(flags_q), .cond_true(cond_true), .stack_empty(stack_empty),
    .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  // Monitor: outputs are stable at the falling edge; pop and compare.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 6;
      if (result_q !== e.res) begin
        errors++;
        $display("FAIL %s result_q: got %h want %h", e.nm, result_q, e.res);
      end
      if (flags_q !== e.flags) begin
        errors++;
        $display("FAIL %s flags_q: got %b want %b", e.nm, flags_q, e.flags);
      end
      if (stack_empty !== e.empty) begin
        errors++;
        $display("FAIL %s stack_empty: got %b want %b", e.nm, stack_empty, e.empty);
      end
      if (stack_full !== e.full) begin
        errors++;
        $display("FAIL %s stack_full: got %b want %b", e.nm, stack_full, e.full);
      end
      if (stack_err !== e.err) begin
        errors++;
        $display("FAIL %s stack_err: got %b want %b", e.nm, stack_err, e.err);
      end
      if (cond_true !== e.cond) begin
        errors++;
        $display("FAIL %s cond_true: got %b want %b", e.nm, cond_true, e.cond);
      end
    end
  end

  // One clock of stimulus; the expectation describes the state after the edge.
  task automatic step(input string nm, input bit rst, input bit cap,
                      input logic [7:0] r_in, input logic [2:0] f_in,
                      input logic [1:0] fop, input logic [2:0] mask,
                      input bit psh, input bit pp, input logic [2:0] csel,
                      input logic [7:0] e_res, input logic [2:0] e_flags,
                      input bit e_empty, input bit e_full, input bit e_err,
                      input bit e_cond);
    exp_t e;
    reset      = rst;
    capture    = cap;
    alu_result = r_in;
    alu_flags  = f_in;
    flag_op    = fop;
    flag_mask  = mask;
    push       = psh;
    pop        = pp;
    cond_sel   = csel;
    @(posedge clock);
    #1;
    e.nm = nm; e.res = e_res; e.flags = e_flags; e.empty = e_empty;
    e.full = e_full; e.err = e_err; e.cond = e_cond;
    exp_q.push_back(e);
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; capture = 1'b0; alu_result = 8'h00; alu_flags = 3'b000;
    flag_op = 2'b00; flag_mask = 3'b000; push = 1'b0; pop = 1'b0; cond_sel = 3'b000;
    #1;
    //    name        rst cap  res    flg    op     mask   psh pop csel     e_res  e_flags                  empty        full err    cond
    step("reset",      1, 0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 0, 3'b001, 8'h00, 3'b001,                  1,           0, 0,     1);
    step("cap80",      0, 1, 8'h80, 3'b010, 2'b00, 3'b000, 0, 0, 3'b101, 8'h80, 3'b010,                  1,           0, 0,     1);
    step("cap00",      0, 1, 8'h00, 3'b000, 2'b00, 3'b000, 0, 0, 3'b000, 8'h00, 3'b000,                  1,           0, 0,     1);
    step("set_c",      0, 0, 8'hEE, 3'b111, 2'b01, 3'b100, 0, 0, 3'b011, 8'h00, 3'b100,                  1,           0, 0,     1);
    step("tog_cz",     0, 0, 8'hEE, 3'b111, 2'b11, 3'b101, 0, 0, 3'b001, 8'h00, 3'b001,                  1,           0, 0,     1);
    step("hold_nz",    0, 0, 8'hEE, 3'b111, 2'b00, 3'b111, 0, 0, 3'b010, 8'h00, 3'b001,                  1,           0, 0,     0);
    step("clr_z",      0, 0, 8'hEE, 3'b111, 2'b10, 3'b001, 0, 0, 3'b111, 8'h00, 3'b000,                  1,           0, 0,     0);
    step("cap_over_op",0, 1, 8'h33, 3'b110, 2'b11, 3'b111, 0, 0, 3'b110, 8'h33, 3'b110,                  1,           0, 0,     0);
    step("cap11",      0, 1, 8'h11, 3'b100, 2'b00, 3'b000, 0, 0, 3'b100, 8'h11, 3'b100,                  1,           0, 0,     0);
    step("push_a",     0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 1, 0, 3'b000, 8'h11, 3'b100,                  !SE,         0, 0,     1);
    step("cap22",      0, 1, 8'h22, 3'b001, 2'b00, 3'b000, 0, 0, 3'b001, 8'h22, 3'b001,                  !SE,         0, 0,     1);
    step("pop_a",      0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 1, 3'b011, 8'h22, SE ? 3'b100 : 3'b001,    1,           0, 0,     SE);
    step("cap44",      0, 1, 8'h44, 3'b000, 2'b00, 3'b000, 0, 0, 3'b001, 8'h44, 3'b000,                  1,           0, 0,     0);
    step("push1",      0, 0, 8'h00, 3'b000, 2'b11, 3'b001, 1, 0, 3'b001, 8'h44, 3'b001,                  !SE,         0, 0,     1);
    step("push2",      0, 0, 8'h00, 3'b000, 2'b11, 3'b010, 1, 0, 3'b101, 8'h44, 3'b011,                  !SE,         0, 0,     1);
    step("push3",      0, 0, 8'h00, 3'b000, 2'b11, 3'b100, 1, 0, 3'b011, 8'h44, 3'b111,                  !SE,         0, 0,     1);
    step("push4",      0, 0, 8'h00, 3'b000, 2'b11, 3'b111, 1, 0, 3'b010, 8'h44, 3'b000,                  !SE,         SE, 0,    1);
    step("push5_over", 0, 0, 8'h00, 3'b000, 2'b11, 3'b001, 1, 0, 3'b001, 8'h44, 3'b001,                  !SE,         SE, SE,   1);
    step("pop1",       0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 1, 3'b011, 8'h44, SE ? 3'b111 : 3'b001,    !SE,         0, SE,    SE);
    step("pop2",       0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 1, 3'b101, 8'h44, SE ? 3'b011 : 3'b001,    !SE,         0, SE,    SE);
    step("pop3",       0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 1, 3'b001, 8'h44, 3'b001,                  !SE,         0, SE,    1);
    step("pop4",       0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 1, 3'b010, 8'h44, SE ? 3'b000 : 3'b001,    1,           0, SE,    SE);
    step("pop5_under", 0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 1, 3'b001, 8'h44, SE ? 3'b000 : 3'b001,    1,           0, SE,    !SE);
    step("pop_empty_cap",0,1, 8'h5A, 3'b110, 2'b00, 3'b000, 0, 1, 3'b110, 8'h5A, 3'b110,                  1,           0, SE,    0);
    step("cap66",      0, 1, 8'h66, 3'b001, 2'b00, 3'b000, 0, 0, 3'b001, 8'h66, 3'b001,                  1,           0, SE,    1);
    step("push_cap77", 0, 1, 8'h77, 3'b010, 2'b00, 3'b000, 1, 0, 3'b101, 8'h77, 3'b010,                  !SE,         0, SE,    1);
    step("pop_cap5A",  0, 1, 8'h5A, 3'b110, 2'b00, 3'b000, 0, 1, 3'b001, 8'h5A, SE ? 3'b001 : 3'b110,    1,           0, SE,    SE);
    step("push_cap01", 0, 1, 8'h01, 3'b100, 2'b00, 3'b000, 1, 0, 3'b011, 8'h01, 3'b100,                  !SE,         0, SE,    1);
    step("push_pop",   0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 1, 1, 3'b000, 8'h01, 3'b100,                  !SE,         0, SE,    1);
    step("pop_b",      0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 1, 3'b011, 8'h01, SE ? 3'b001 : 3'b100,    1,           0, SE,    !SE);
    step("push_r1",    0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 1, 0, 3'b000, 8'h01, SE ? 3'b001 : 3'b100,    !SE,         0, SE,    1);
    step("push_r2",    0, 0, 8'h00, 3'b000, 2'b00, 3'b000, 1, 0, 3'b000, 8'h01, SE ? 3'b001 : 3'b100,    !SE,         0, SE,    1);
    step("mid_reset",  1, 1, 8'hFF, 3'b111, 2'b11, 3'b111, 1, 0, 3'b000, 8'h00, 3'b001,                  1,           0, 0,     1);
    step("pop_after_rst",0,0, 8'h00, 3'b000, 2'b00, 3'b000, 0, 1, 3'b010, 8'h00, 3'b001,                  1,           0, SE,    0);
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      @(negedge clock);
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
